debounce_multi: RTL and testbench

DEBOUNCE_MULTI -- requirements
Module: debounce_multi

---
 rtl/debounce_pkg.sv | 25 ++
 rtl/debounce_channel.sv | 95 +++++++++
 rtl/debounce_multi.sv | 84 ++++++++
 tb/tb_debounce_multi.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
`default_nettype none
// ============================================================================
// Module      : debounce_pkg
// Description : Shared state encoding and default sizing for debounce_multi.
// Revision    : 1.0  initial release
// ============================================================================
package debounce_pkg;

    localparam int DEF_CH = 4;
    localparam int DEF_N  = 21;

    typedef enum logic [1:0] {
        ZERO  = 2'b00,
        WAIT0 = 2'b01,
        ONE   = 2'b10,
        WAIT1 = 2'b11
    } db_state_e;

    // The encoding makes the debounced level the XOR of the two state bits.
    function automatic logic state_level(input db_state_e st);
        return st[1] ^ st[0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_channel.sv
`default_nettype none
// ============================================================================
// Module      : debounce_channel
// Description : One switch channel: four-state debounce FSM with N-bit
//               down-counter and registered level / edge-pulse outputs.
// Revision    : 1.0  initial release
// ============================================================================
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int N = DEF_N
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_ce,
    input  logic i_s,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    localparam logic [N-1:0] CNT_LAST = {{(N-1){1'b0}}, 1'b1};

    db_state_e    state_q, state_d;
    logic [N-1:0] cnt_q,   cnt_d;
    logic         level_q, level_d;
    logic         rise_q,  rise_d;
    logic         fall_q,  fall_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        unique case (state_q)
            ZERO: begin
                if (i_s) begin
                    state_d = WAIT1;
                    cnt_d   = '1;
                end
            end
            WAIT1: begin
                if (!i_s) begin
                    state_d = ZERO;
                end else if (i_ce && (cnt_q != '0)) begin
                    cnt_d = cnt_q - CNT_LAST;
                    if (cnt_q == CNT_LAST) begin
                        state_d = ONE;
                        rise_d  = 1'b1;
                    end
                end
            end
            ONE: begin
                if (!i_s) begin
                    state_d = WAIT0;
                    cnt_d   = '1;
                end
            end
            WAIT0: begin
                if (i_s) begin
                    state_d = ONE;
                end else if (i_ce && (cnt_q != '0)) begin
                    cnt_d = cnt_q - CNT_LAST;
                    if (cnt_q == CNT_LAST) begin
                        state_d = ZERO;
                        fall_d  = 1'b1;
                    end
                end
            end
        endcase
        level_d = state_level(state_d);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ZERO;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign o_level = level_q;
    assign o_rise  = rise_q;
    assign o_fall  = fall_q;

endmodule
`default_nettype wire

// File: rtl/debounce_multi.sv
`default_nettype none
// ============================================================================
// Module      : debounce_multi
// Description : CH independent switch debouncers with level, rise/fall pulses
//               and a registered any_change flag.
//               Define DEBOUNCE_SYNC_EN to add a two-flop input synchronizer.
// Revision    : 1.0  initial release
// ============================================================================
module debounce_multi
    import debounce_pkg::*;
#(
    parameter int CH = DEF_CH,
    parameter int N  = DEF_N
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          ce,
    input  logic [CH-1:0] sw,
    output logic [CH-1:0] db_level,
    output logic [CH-1:0] db_rise,
    output logic [CH-1:0] db_fall,
    output logic          any_change
);

    logic [CH-1:0] s;

`ifdef DEBOUNCE_SYNC_EN
    logic [CH-1:0] sync1_q, sync1_d;
    logic [CH-1:0] sync2_q, sync2_d;

    always_comb begin
        sync1_d = sw;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign s = sync2_q;
`else
    assign s = sw;
`endif

    generate
        for (genvar g = 0; g < CH; g++) begin : g_ch
            debounce_channel #(
                .N (N)
            ) u_channel (
                .clk     (clk),
                .reset_n (reset_n),
                .i_ce    (ce),
                .i_s     (s[g]),
                .o_level (db_level[g]),
                .o_rise  (db_rise[g]),
                .o_fall  (db_fall[g])
            );
        end
    endgenerate

    logic any_change_q, any_change_d;

    always_comb begin
        any_change_d = |{db_rise, db_fall};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            any_change_q <= 1'b0;
        end else begin
            any_change_q <= any_change_d;
        end
    end

    assign any_change = any_change_q;

endmodule
`default_nettype wire

// File: tb/tb_debounce_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_debounce_multi
// Description : Self-checking bench for debounce_multi (CH=4, N=4).
// Revision    : 1.0  initial release
// ============================================================================
module tb_debounce_multi;

    localparam int CH   = 4;
    localparam int N    = 4;
    localparam int FULL = (1 << N) - 1;
`ifdef DEBOUNCE_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic          clk;
    logic          reset_n;
    logic          ce;
    logic [CH-1:0] sw;
    logic [CH-1:0] db_level;
    logic [CH-1:0] db_rise;
    logic [CH-1:0] db_fall;
    logic          any_change;

    int checks;
    int errors;

    debounce_multi #(
        .CH (CH),
        .N  (N)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ce         (ce),
        .sw         (sw),
        .db_level   (db_level),
        .db_rise    (db_rise),
        .db_fall    (db_fall),
        .any_change (any_change)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: a channel flips once its input has disagreed with the level
    // on a first edge and then on FULL further ce-qualified edges in a row.
    logic [CH-1:0] m_level, m_rise, m_fall, m_pend;
    logic          m_any;
    int            m_cnt [CH];
    logic [CH-1:0] m_hist [2];

    task automatic model_reset();
        m_level = '0; m_rise = '0; m_fall = '0; m_pend = '0; m_any = 1'b0;
        m_hist[0] = '0; m_hist[1] = '0;
        for (int i = 0; i < CH; i++) m_cnt[i] = 0;
    endtask

    task automatic model_edge(input logic [CH-1:0] sw_v, input logic ce_v);
        logic [CH-1:0] s;
        s = (LAT == 2) ? m_hist[1] : sw_v;
        m_hist[1] = m_hist[0];
        m_hist[0] = sw_v;
        m_any  = |{m_rise, m_fall};
        m_rise = '0;
        m_fall = '0;
        for (int i = 0; i < CH; i++) begin
            if (s[i] == m_level[i]) begin
                m_pend[i] = 1'b0;
            end else if (!m_pend[i]) begin
                m_pend[i] = 1'b1;
                m_cnt[i]  = 0;
            end else if (ce_v) begin
                m_cnt[i]++;
                if (m_cnt[i] == FULL) begin
                    m_level[i] = s[i];
                    m_rise[i]  = s[i];
                    m_fall[i]  = !s[i];
                    m_pend[i]  = 1'b0;
                end
            end
        end
    endtask

    task automatic check_val(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic check_model(input string name);
        checks++;
        if ({db_level, db_rise, db_fall, any_change} !== {m_level, m_rise, m_fall, m_any}) begin
            errors++;
            $display("FAIL %s @%0t: got level=%h rise=%h fall=%h any=%b, want level=%h rise=%h fall=%h any=%b",
                     name, $time, db_level, db_rise, db_fall, any_change,
                     m_level, m_rise, m_fall, m_any);
        end
    endtask

    task automatic step(input logic [CH-1:0] sw_v, input logic ce_v, input string name);
        sw = sw_v;
        ce = ce_v;
        @(posedge clk);
        model_edge(sw_v, ce_v);
        #1;
        check_model(name);
    endtask

    task automatic do_reset(input logic [CH-1:0] sw_v);
        sw      = sw_v;
        ce      = 1'b1;
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_val("reset_outputs", int'({db_level, db_rise, db_fall, any_change}), 0);
        reset_n = 1'b1;
    endtask

    typedef struct {
        logic [CH-1:0] sw;
        logic          ce;
        int            cycles;
        logic [CH-1:0] exp_level;
        int            exp_rises;
        int            exp_falls;
    } seg_t;

    seg_t tbl [6];

    initial begin
        int rises, falls, t_hit, n_f, n_full, n_any;
        logic [CH-1:0] v;
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        ce      = 1'b1;
        sw      = '0;
        model_reset();

        // ch0 rise/fall: exact edge of the level change
        tbl[0] = '{4'h0, 1'b1, 4,          4'h0, 0, 0};
        tbl[1] = '{4'h1, 1'b1, FULL + LAT, 4'h0, 0, 0};
        tbl[2] = '{4'h1, 1'b1, 1,          4'h1, 1, 0};
        tbl[3] = '{4'h1, 1'b1, 2,          4'h1, 0, 0};
        tbl[4] = '{4'h0, 1'b1, FULL + LAT, 4'h1, 0, 0};
        tbl[5] = '{4'h0, 1'b1, 1,          4'h0, 0, 1};
        do_reset('0);
        for (int r = 0; r < 6; r++) begin
            rises = 0;
            falls = 0;
            for (int c = 0; c < tbl[r].cycles; c++) begin
                step(tbl[r].sw, tbl[r].ce, "tbl_step");
                rises += int'(db_rise[0]);
                falls += int'(db_fall[0]);
            end
            check_val($sformatf("tbl%0d_level", r), int'(db_level), int'(tbl[r].exp_level));
            check_val($sformatf("tbl%0d_rises", r), rises, tbl[r].exp_rises);
            check_val($sformatf("tbl%0d_falls", r), falls, tbl[r].exp_falls);
        end

        // ch1 glitch after 10 cycles restarts the count
        do_reset('0);
        t_hit = 0;
        rises = 0;
        for (int c = 1; c <= 40; c++) begin
            step((c == 11) ? 4'h0 : 4'h2, 1'b1, "glitch_step");
            if (db_rise[1]) begin
                rises++;
                if (t_hit == 0) t_hit = c;
            end
        end
        check_val("glitch_rise_step", t_hit, 27 + LAT);
        check_val("glitch_rise_count", rises, 1);

        // ch2 with ce alternating 1/0
        do_reset('0);
        t_hit = 0;
        for (int c = 1; c <= 45; c++) begin
            step(4'h4, (c % 2) == 1, "ce_step");
            if (db_rise[2] && t_hit == 0) t_hit = c;
        end
        check_val("ce_rise_step", t_hit, 31 + LAT);

        // all channels fall together
        do_reset('0);
        for (int c = 0; c < 20 + LAT; c++) step(4'hF, 1'b1, "all_up_step");
        n_f = 0; n_full = 0; n_any = 0;
        for (int c = 0; c < 22 + LAT; c++) begin
            step(4'h0, 1'b1, "all_down_step");
            if (db_fall != '0) n_f++;
            if (db_fall == 4'hF) n_full++;
            n_any += int'(any_change);
        end
        check_val("all_fall_level", int'(db_level), 0);
        check_val("all_fall_cycles", n_f, 1);
        check_val("all_fall_full", n_full, 1);
        check_val("all_fall_any", n_any, 1);

        // asynchronous reset mid-WAIT1 on ch3
        do_reset('0);
        for (int c = 0; c < 8; c++) step(4'h8, 1'b1, "pre_async_step");
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_val("async_reset_outputs", int'({db_level, db_rise, db_fall, any_change}), 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        t_hit = 0;
        rises = 0;
        for (int c = 1; c <= 25 + LAT; c++) begin
            step(4'h8, 1'b1, "post_async_step");
            if (db_rise[3]) begin
                rises++;
                if (t_hit == 0) t_hit = c;
            end
        end
        check_val("post_async_rise_step", t_hit, 16 + LAT);
        check_val("post_async_rise_count", rises, 1);

        // randomized run against the reference
        do_reset('0);
        v = '0;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 5) == 0) v[$urandom_range(0, CH - 1)] ^= 1'b1;
            step(v, $urandom_range(0, 3) != 0, "rand_step");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
